ram_burst_ctrl: RTL
===================

Name: ram_burst_ctrl

Overview:
- Master-side controller that sits directly upstream of the 32x32 single-port RAM with the bidirectional data bus.
- Converts valid/ready burst requests (1–32 words, write or read) into the RAM's ena/wena/addr/data_io cycle sequence.
- Owns the tristate side of data_io.
- Returns read words on a valid/ready stream.

Parameters:
- AW, 5, RAM address width; depth is 2**AW words.
- DW, 32, data word width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  burst request valid.
- req_ready  out  1  controller idle, accepts a request.
- req_write  in  1  1 = write burst, 0 = read burst.
- req_addr  in  AW  start address.
- req_len  in  AW  beats minus one (0 → 1 word, 31 → 32 words).
- wr_valid  in  1  write data beat valid.
- wr_ready  out  1  controller consumes the write beat.
- wr_data  in  DW  write data.
- rd_valid  out  1  read data valid.
- rd_ready  in  1  downstream accepts the read beat.
- rd_data  out  DW  read data, registered.
- busy  out  1  burst in progress (not IDLE).
- done  out  1  one-cycle pulse at end of each burst.
- ram_ena  out  1  RAM enable.
- ram_wena  out  1  RAM write enable.
- ram_addr  out  AW  RAM address.
- ram_data  inout  DW  RAM data bus; driven with wr_data only when ram_wena=1, else high-Z.

Behaviour:
- RAM contract:
  - Write at the rising clk edge when ena=1 and wena=1.
  - Read is combinational from addr when ena=1 and wena=0.
  - With ena=0, the RAM floats the bus.
- Reset (async, immediate):
  - State=IDLE.
  - req_ready=1; wr_ready=0; rd_valid=0; rd_data=0; busy=0; done=0.
  - ram_ena=0; ram_wena=0; ram_addr=0.
  - ram_data high-Z.
  - A reset mid-burst abandons the burst; there is no resume.
- Registers:
  - cur_addr (AW bits).
  - remain (AW bits).
  - State: IDLE, WRITE, READ, TURN.
- IDLE:
  - req_ready=1; ram_ena=0.
  - On req_valid: latch cur_addr←req_addr and remain←req_len.
  - Go to WRITE if req_write, else READ.
  - The request is accepted in one cycle; req_ready drops the next cycle.
- WRITE:
  - ram_ena=1; ram_addr=cur_addr; wr_ready=1.
  - ram_wena=wr_valid, combinational; ram_data=wr_data while ram_wena=1.
  - Each cycle with wr_valid=1 writes one word, then cur_addr←cur_addr+1 mod 2**AW.
  - If remain=0, go to TURN; else remain←remain−1.
  - wr_valid=0 stalls with no write and the address holds.
- READ:
  - ram_ena=1; ram_wena=0; ram_addr=cur_addr; bus released.
  - Capture condition: rd_valid=0 or rd_ready=1.
  - On capture: rd_data←ram_data; rd_valid←1; address and remain advance as in WRITE.
  - On the last beat, go to TURN.
  - Otherwise, rd_valid drops after handshake when no new capture occurs.
  - Latency: address presented in cycle N, data on rd_data with rd_valid in cycle N+1.
  - Full throughput is one word per cycle when rd_ready=1.
  - Backpressure: rd_valid && !rd_ready holds rd_data, cur_addr and remain stable.
- TURN (exactly one cycle):
  - ram_ena=0; ram_wena=0; bus high-Z; done=1.
  - Go to IDLE.
  - The last read beat may still be pending in rd_valid; IDLE accepts a new request only when rd_valid=0 or rd_ready=1 in that cycle.
- Wrap-around: the address wraps 31→0 within a burst. A 32-beat burst from any start address touches every word exactly once.
- Simultaneous events:
  - A req_valid during a burst is ignored (req_ready=0).
  - wr_valid outside WRITE is ignored (wr_ready=0).
- Bus contention rule: the controller never drives ram_data in any cycle with ram_wena=0.

Test Plan:
- Reset mid-WRITE (assert rst while ram_wena=1) → ram_wena=0 and ram_data high-Z in the same cycle; req_ready=1 after release.
- Write len=0, addr=1, data=32'h00000001, then read len=0, addr=1 → rd_data=1 one cycle after ram_addr=1; done pulses once per burst.
- Write len=3 at addr=30 with data A0..A3 → words land at 30, 31, 0, 1. Read len=3 at addr=30 → the same order returned.
- Write burst with wr_valid low every other cycle (data f0ff0f0f, ff00ff00) → exactly 2 writes, address holds during gaps, burst length is 4 cycles.
- Read len=31 with rd_ready held low for 3 cycles mid-burst → rd_data stable and ram_addr frozen during the stall; all 32 words are returned in order with no duplicates.
- Checker across all tests: whenever ram_wena=0, the controller never drives ram_data. One TURN cycle with ram_ena=0 separates a write burst from a following read burst.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// ram_burst_ctrl
//
// Master-side burst controller for a single-port RAM with a shared,
// bidirectional data bus. A burst request (1..2**AW words, read or write)
// is turned into the RAM's ena/wena/addr cycle sequence. Write beats are
// streamed in, and read words are streamed out.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both 1. A producer holds valid and its payload until that edge. Ready
// may depend combinationally on the state of the controller.
//
// Ports
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req_*             burst request (write flag, start address, beats-1)
//   wr_*              write data stream (consumed only during a write burst)
//   rd_*              read data stream (rd_data registered)
//   busy, done        burst in progress / one-cycle end-of-burst pulse
//   ram_ena/wena/addr RAM control
//   ram_data          RAM data bus; driven only while ram_wena=1

module ram_burst_ctrl #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_write,
    input  logic [AW-1:0] req_addr,
    input  logic [AW-1:0] req_len,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic          busy,
    output logic          done,
    output logic          ram_ena,
    output logic          ram_wena,
    output logic [AW-1:0] ram_addr,
    inout  wire  [DW-1:0] ram_data
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_READ  = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    localparam logic [AW-1:0] ONE = {{(AW-1){1'b0}}, 1'b1};

    logic [1:0]    state_q,    state_d;
    logic [AW-1:0] cur_addr_q, cur_addr_d;
    logic [AW-1:0] remain_q,   remain_d;
    logic          rd_valid_q, rd_valid_d;
    logic [DW-1:0] rd_data_q,  rd_data_d;
    logic          rd_capture;

    // The bus is owned by the controller only during an actual write beat,
    // so it can never fight the RAM's read driver.
    assign ram_data = ram_wena ? wr_data : {DW{1'bz}};

    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign busy     = (state_q != S_IDLE);
    assign done     = (state_q == S_TURN);

    // Per-state outputs.
    always_comb begin
        req_ready  = 1'b0;
        wr_ready   = 1'b0;
        ram_ena    = 1'b0;
        ram_wena   = 1'b0;
        ram_addr   = '0;
        rd_capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                // A read word left over from the previous burst must leave
                // the output register before a new burst may start.
                req_ready = !rd_valid_q || rd_ready;
            end
            S_WRITE: begin
                ram_ena  = 1'b1;
                wr_ready = 1'b1;
                ram_wena = wr_valid;
                ram_addr = cur_addr_q;
            end
            S_READ: begin
                ram_ena    = 1'b1;
                ram_addr   = cur_addr_q;
                // The output register is free, or it is emptied this cycle.
                rd_capture = !rd_valid_q || rd_ready;
            end
            default: ;
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        remain_d   = remain_q;
        rd_valid_d = rd_valid_q;
        rd_data_d  = rd_data_q;

        if (rd_valid_q && rd_ready) begin
            rd_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    cur_addr_d = req_addr;
                    remain_d   = req_len;
                    state_d    = req_write ? S_WRITE : S_READ;
                end
            end
            S_WRITE: begin
                if (wr_valid) begin
                    // Address wraps naturally at 2**AW.
                    cur_addr_d = cur_addr_q + ONE;
                    if (remain_q == '0) begin
                        state_d = S_TURN;
                    end else begin
                        remain_d = remain_q - ONE;
                    end
                end
            end
            S_READ: begin
                if (rd_capture) begin
                    rd_data_d  = ram_data;
                    rd_valid_d = 1'b1;
                    cur_addr_d = cur_addr_q + ONE;
                    if (remain_q == '0) begin
                        state_d = S_TURN;
                    end else begin
                        remain_d = remain_q - ONE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            remain_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            remain_q   <= remain_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

endmodule
